// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its read tracker.
package datamem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic owner;
    } rd_tag_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/datamem_rd_tracker.sv
// Read-ownership pipe: one tag per issued BRAM access, aligned with the BRAM
// read latency so the tag at the pipe output matches mem_rdata.
module datamem_rd_tracker
    import datamem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld,
    input  logic push_owner,
    output logic rsp_valid0,
    output logic rsp_valid1
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("datamem_rd_tracker: RD_LATENCY must be in 1..4");
    end

    rd_tag_t [RD_LATENCY-1:0] pipe;
    rd_tag_t                  head;

    // Shift one tag per cycle; reset drops every in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{vld: push_vld, owner: push_vld & push_owner};
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign head       = pipe[RD_LATENCY-1];
    assign rsp_valid0 = head.vld && (head.owner == REQ_CPU);
    assign rsp_valid1 = head.vld && (head.owner == REQ_DMA);

endmodule

// File: rtl/datamem_arbiter.sv
// Two-requester arbiter for the single-port data BRAM (m0 = CPU, m1 = DMA).
// Optional build macro DATAMEM_ARB_PERF_EN adds grant/conflict counters.
//
// state | meaning
// ARB   | per-cycle round robin; m0 wins the first conflict after reset
// LOCK  | m1 burst; m0 only gets cycles m1 leaves idle
// FORCE | one slot forced to m0 after LOCK_MAX m1 grants under lock
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter  int DATAMEM_DEPTH = 8192,
    parameter  int RD_LATENCY    = 1,
    parameter  int LOCK_MAX      = 16,
    localparam int AW            = $clog2(DATAMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cmd_valid,
    output logic          m0_cmd_ready,
    input  logic [AW-1:0] m0_cmd_addr,
    input  logic [31:0]   m0_cmd_wdata,
    input  logic [3:0]    m0_cmd_mask,
    input  logic          m0_cmd_wr,
    input  logic          m1_cmd_valid,
    output logic          m1_cmd_ready,
    input  logic [AW-1:0] m1_cmd_addr,
    input  logic [31:0]   m1_cmd_wdata,
    input  logic [3:0]    m1_cmd_mask,
    input  logic          m1_cmd_wr,
    input  logic          m1_lock,
    output logic [31:0]   m0_rsp_data,
    output logic          m0_rsp_valid,
    output logic [31:0]   m1_rsp_data,
    output logic          m1_rsp_valid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_mask,
    input  logic [31:0]   mem_rdata
`ifdef DATAMEM_ARB_PERF_EN
    ,
    input  logic          perf_clr,
    output logic [31:0]   perf_grant0,
    output logic [31:0]   perf_grant1,
    output logic [31:0]   perf_conflict
`endif
);

    localparam int             LCW         = $clog2(LOCK_MAX + 1);
    localparam logic [LCW-1:0] LOCK_MAX_C  = LCW'(LOCK_MAX);
    localparam logic [LCW-1:0] LOCK_MAX_M1 = LCW'(LOCK_MAX - 1);
    localparam logic [LCW-1:0] LOCK_ONE    = LCW'(1);

    arb_state_e     state, state_nxt;
    logic [LCW-1:0] lock_cnt, lock_cnt_nxt;
    logic           last_grant, last_grant_nxt;
    logic           grant0, grant1;
    logic           rsp_valid0, rsp_valid1;

    // Arbiter state, burst counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            lock_cnt   <= '0;
            last_grant <= REQ_DMA;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= lock_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Grant decision and next state; grants are held off while reset is high
    // so every output reads 0 during reset.
    always_comb begin
        grant0         = 1'b0;
        grant1         = 1'b0;
        state_nxt      = state;
        lock_cnt_nxt   = lock_cnt;
        last_grant_nxt = last_grant;
        if (!rst) begin
            case (state)
                ARB: begin
                    if (m0_cmd_valid && m1_cmd_valid) begin
                        grant0 = (last_grant == REQ_DMA);
                        grant1 = (last_grant == REQ_CPU);
                    end else begin
                        grant0 = m0_cmd_valid;
                        grant1 = m1_cmd_valid;
                    end
                    if (grant1 && m1_lock) begin
                        state_nxt    = LOCK;
                        lock_cnt_nxt = LOCK_ONE;
                    end
                end
                LOCK: begin
                    grant1 = m1_cmd_valid;
                    grant0 = m0_cmd_valid && !m1_cmd_valid;
                    if (grant1 && lock_cnt < LOCK_MAX_C) begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                    // The grant that brings the count to LOCK_MAX is the last
                    // one m1 gets before a waiting m0 is served.
                    if (!m1_lock) begin
                        state_nxt = ARB;
                    end else if (grant1 && m0_cmd_valid && lock_cnt >= LOCK_MAX_M1) begin
                        state_nxt = FORCE;
                    end
                end
                FORCE: begin
                    grant0 = m0_cmd_valid;
                    grant1 = m1_cmd_valid && !m0_cmd_valid;
                    if (m1_lock) begin
                        state_nxt    = LOCK;
                        lock_cnt_nxt = LOCK_ONE;
                    end else begin
                        state_nxt = ARB;
                    end
                end
                default: state_nxt = ARB;
            endcase
            if (grant0 || grant1) begin
                last_grant_nxt = grant1;
            end
            if (state == LOCK && !m1_lock) begin
                last_grant_nxt = REQ_DMA;
            end
        end
    end

    // Steer the granted requester's command onto the BRAM port.
    always_comb begin
        mem_en    = grant0 | grant1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        if (grant0) begin
            mem_we    = m0_cmd_wr;
            mem_addr  = m0_cmd_addr;
            mem_wdata = m0_cmd_wdata;
            mem_mask  = m0_cmd_mask;
        end else if (grant1) begin
            mem_we    = m1_cmd_wr;
            mem_addr  = m1_cmd_addr;
            mem_wdata = m1_cmd_wdata;
            mem_mask  = m1_cmd_mask;
        end
    end

    assign m0_cmd_ready = grant0;
    assign m1_cmd_ready = grant1;

    datamem_rd_tracker #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tracker (
        .clk        (clk),
        .rst        (rst),
        .push_vld   ((grant0 && !m0_cmd_wr) || (grant1 && !m1_cmd_wr)),
        .push_owner (grant1),
        .rsp_valid0 (rsp_valid0),
        .rsp_valid1 (rsp_valid1)
    );

    assign m0_rsp_valid = rsp_valid0;
    assign m1_rsp_valid = rsp_valid1;
    assign m0_rsp_data  = rsp_valid0 ? mem_rdata : 32'h0;
    assign m1_rsp_data  = rsp_valid1 ? mem_rdata : 32'h0;

`ifdef DATAMEM_ARB_PERF_EN
    // Saturating grant/conflict counters; perf_clr beats any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else if (perf_clr) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant0 && perf_grant0 != 32'hFFFF_FFFF) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end
            if (grant1 && perf_grant1 != 32'hFFFF_FFFF) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if (m0_cmd_valid && m1_cmd_valid && perf_conflict != 32'hFFFF_FFFF) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: two instances (RD_LATENCY 1 and 3) see the same
// commands; read responses are checked by a scoreboard on data and arrival cycle.
module tb_datamem_arbiter;

    localparam int AW = 13;

    typedef struct packed {
        logic          v;
        logic          wr;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    m;
    } cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_cmd_valid, m1_cmd_valid, m0_cmd_wr, m1_cmd_wr, m1_lock;
    logic [AW-1:0] m0_cmd_addr, m1_cmd_addr;
    logic [31:0]   m0_cmd_wdata, m1_cmd_wdata;
    logic [3:0]    m0_cmd_mask, m1_cmd_mask;

    logic          a_m0_cmd_ready, a_m1_cmd_ready, a_m0_rsp_valid, a_m1_rsp_valid, a_mem_en, a_mem_we;
    logic [31:0]   a_m0_rsp_data, a_m1_rsp_data, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0] a_mem_addr;
    logic [3:0]    a_mem_mask;
    logic          b_m0_cmd_ready, b_m1_cmd_ready, b_m0_rsp_valid, b_m1_rsp_valid, b_mem_en, b_mem_we;
    logic [31:0]   b_m0_rsp_data, b_m1_rsp_data, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;
    logic [3:0]    b_mem_mask;
`ifdef DATAMEM_ARB_PERF_EN
    logic          perf_clr;
    logic [31:0]   a_perf_grant0, a_perf_grant1, a_perf_conflict;
    logic [31:0]   b_perf_grant0, b_perf_grant1, b_perf_conflict;
`endif

    datamem_arbiter #(.DATAMEM_DEPTH(8192), .RD_LATENCY(1), .LOCK_MAX(16)) dut_a (
        .clk(clk), .rst(rst),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(a_m0_cmd_ready), .m0_cmd_addr(m0_cmd_addr),
        .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_mask(m0_cmd_mask), .m0_cmd_wr(m0_cmd_wr),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(a_m1_cmd_ready), .m1_cmd_addr(m1_cmd_addr),
        .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_mask(m1_cmd_mask), .m1_cmd_wr(m1_cmd_wr),
        .m1_lock(m1_lock),
        .m0_rsp_data(a_m0_rsp_data), .m0_rsp_valid(a_m0_rsp_valid),
        .m1_rsp_data(a_m1_rsp_data), .m1_rsp_valid(a_m1_rsp_valid),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_mask(a_mem_mask), .mem_rdata(a_mem_rdata)
`ifdef DATAMEM_ARB_PERF_EN
        , .perf_clr(perf_clr), .perf_grant0(a_perf_grant0), .perf_grant1(a_perf_grant1),
        .perf_conflict(a_perf_conflict)
`endif
    );

    datamem_arbiter #(.DATAMEM_DEPTH(8192), .RD_LATENCY(3), .LOCK_MAX(16)) dut_b (
        .clk(clk), .rst(rst),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(b_m0_cmd_ready), .m0_cmd_addr(m0_cmd_addr),
        .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_mask(m0_cmd_mask), .m0_cmd_wr(m0_cmd_wr),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(b_m1_cmd_ready), .m1_cmd_addr(m1_cmd_addr),
        .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_mask(m1_cmd_mask), .m1_cmd_wr(m1_cmd_wr),
        .m1_lock(m1_lock),
        .m0_rsp_data(b_m0_rsp_data), .m0_rsp_valid(b_m0_rsp_valid),
        .m1_rsp_data(b_m1_rsp_data), .m1_rsp_valid(b_m1_rsp_valid),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_mask(b_mem_mask), .mem_rdata(b_mem_rdata)
`ifdef DATAMEM_ARB_PERF_EN
        , .perf_clr(perf_clr), .perf_grant0(b_perf_grant0), .perf_grant1(b_perf_grant1),
        .perf_conflict(b_perf_conflict)
`endif
    );

    // BRAM model: contents written through dut_a (both duts issue identical
    // accesses); each dut gets its own read-latency pipe.
    logic [31:0] mem [0:8191];
    logic [31:0] rp_a;
    logic [31:0] rp_b [0:2];
    initial for (int i = 0; i < 8192; i++) mem[i] = 32'h5A00_0000 + 32'(i);

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we)
            for (int j = 0; j < 4; j++)
                if (a_mem_mask[j]) mem[a_mem_addr][8*j +: 8] <= a_mem_wdata[8*j +: 8];
        if (a_mem_en && !a_mem_we) rp_a <= mem[a_mem_addr];
        if (b_mem_en && !b_mem_we) rp_b[0] <= mem[b_mem_addr];
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end
    assign a_mem_rdata = rp_a;
    assign b_mem_rdata = rp_b[2];

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t qa0[$], qa1[$], qb0[$], qb1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_rsp(input string nm, input logic v, input logic [31:0] d, ref exp_t q[$]);
        exp_t e;
        n_cmp++;
        if (v) begin
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL %s: unexpected rsp data %h at cyc %0d, want none", nm, d, cyc);
            end else begin
                e = q.pop_front();
                if (d !== e.data || cyc !== e.at) begin
                    n_bad++;
                    $display("FAIL %s: got data %h at cyc %0d, want %h at cyc %0d", nm, d, cyc, e.data, e.at);
                end
            end
        end else if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL %s_idle_data: got %h, want 00000000", nm, d);
        end
    endtask

    // Monitor: every response pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk_rsp("a_m0_rsp", a_m0_rsp_valid, a_m0_rsp_data, qa0);
            chk_rsp("a_m1_rsp", a_m1_rsp_valid, a_m1_rsp_data, qa1);
            chk_rsp("b_m0_rsp", b_m0_rsp_valid, b_m0_rsp_data, qb0);
            chk_rsp("b_m1_rsp", b_m1_rsp_valid, b_m1_rsp_data, qb1);
        end
    end

    function automatic cmd_t rd(input logic [AW-1:0] a);
        cmd_t c = '0;
        c.v = 1'b1;
        c.a = a;
        return c;
    endfunction

    function automatic cmd_t wrc(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        cmd_t c = '0;
        c.v  = 1'b1;
        c.wr = 1'b1;
        c.a  = a;
        c.d  = d;
        c.m  = m;
        return c;
    endfunction

    localparam cmd_t IDLE = '0;

    // One cycle: drive, check grants mid-cycle, queue expected read data.
    task automatic step(input cmd_t c0, input cmd_t c1, input logic lk,
                        input logic er0, input logic er1,
                        input logic [31:0] ed0, input logic [31:0] ed1);
        m0_cmd_valid = c0.v; m0_cmd_wr = c0.wr; m0_cmd_addr = c0.a;
        m0_cmd_wdata = c0.d; m0_cmd_mask = c0.m;
        m1_cmd_valid = c1.v; m1_cmd_wr = c1.wr; m1_cmd_addr = c1.a;
        m1_cmd_wdata = c1.d; m1_cmd_mask = c1.m;
        m1_lock      = lk;
        @(negedge clk);
        chk("a_ready0", 32'(a_m0_cmd_ready), 32'(er0));
        chk("a_ready1", 32'(a_m1_cmd_ready), 32'(er1));
        chk("b_ready0", 32'(b_m0_cmd_ready), 32'(er0));
        chk("b_ready1", 32'(b_m1_cmd_ready), 32'(er1));
        if (er0 && c0.v && !c0.wr) begin
            qa0.push_back('{data: ed0, at: cyc + 32'd1});
            qb0.push_back('{data: ed0, at: cyc + 32'd3});
        end
        if (er1 && c1.v && !c1.wr) begin
            qa1.push_back('{data: ed1, at: cyc + 32'd1});
            qb1.push_back('{data: ed1, at: cyc + 32'd3});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(IDLE, IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_a_ctl"}, 32'({a_m0_cmd_ready, a_m1_cmd_ready, a_mem_en, a_mem_we,
                               a_m0_rsp_valid, a_m1_rsp_valid, a_mem_mask}), 32'h0);
        chk({nm, "_a_addr"}, 32'(a_mem_addr), 32'h0);
        chk({nm, "_a_wdata"}, a_mem_wdata, 32'h0);
        chk({nm, "_a_rdata"}, a_m0_rsp_data | a_m1_rsp_data, 32'h0);
        chk({nm, "_b_ctl"}, 32'({b_m0_cmd_ready, b_m1_cmd_ready, b_mem_en, b_mem_we,
                               b_m0_rsp_valid, b_m1_rsp_valid, b_mem_mask}), 32'h0);
        chk({nm, "_b_addr"}, 32'(b_mem_addr), 32'h0);
        chk({nm, "_b_rdata"}, b_m0_rsp_data | b_m1_rsp_data, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    cmd_t c0;
    int   k;
    logic done0;

    initial begin
        rst = 1'b1;
        m0_cmd_valid = 0; m0_cmd_wr = 0; m0_cmd_addr = '0; m0_cmd_wdata = '0; m0_cmd_mask = '0;
        m1_cmd_valid = 0; m1_cmd_wr = 0; m1_cmd_addr = '0; m1_cmd_wdata = '0; m1_cmd_mask = '0;
        m1_lock = 0;
`ifdef DATAMEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Conflicting reads alternate m0, m1, m0, m1 (m0 first after reset).
        step(rd(13'h020), rd(13'h030), 1'b0, 1'b1, 1'b0, 32'h5A00_0020, 32'h0);
        step(rd(13'h021), rd(13'h030), 1'b0, 1'b0, 1'b1, 32'h0, 32'h5A00_0030);
        step(rd(13'h021), rd(13'h031), 1'b0, 1'b1, 1'b0, 32'h5A00_0021, 32'h0);
        step(rd(13'h022), rd(13'h031), 1'b0, 1'b0, 1'b1, 32'h0, 32'h5A00_0031);
`ifdef DATAMEM_ARB_PERF_EN
        chk("perf_conflict", a_perf_conflict, 32'd4);
        chk("perf_grant0", a_perf_grant0, 32'd2);
        chk("perf_grant1", a_perf_grant1, 32'd2);
`endif
        idle(4);

        // m0 alone, back-to-back reads.
        step(rd(13'h010), IDLE, 1'b0, 1'b1, 1'b0, 32'h5A00_0010, 32'h0);
        step(rd(13'h011), IDLE, 1'b0, 1'b1, 1'b0, 32'h5A00_0011, 32'h0);
        idle(4);

        // Masked write by m1, then m0 reads it back on the next cycle.
        step(IDLE, wrc(13'h100, 32'hDEAD_BEEF, 4'b0011), 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(rd(13'h100), IDLE, 1'b0, 1'b1, 1'b0, 32'h5A00_BEEF, 32'h0);
        idle(4);

        // Locked m1 write burst with m0 waiting from the 2nd cycle:
        // m1 cycles 1..16, m0 cycle 17, m1 cycles 18..21.
        k = 0;
        done0 = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            c0 = (c >= 2 && !done0) ? rd(13'h040) : IDLE;
            step(c0, wrc(13'(32'h200 + k), 32'h1000_0000 + 32'(k), 4'hF), 1'b1,
                 (c == 17), (c != 17), 32'h5A00_0040, 32'h0);
            if (c == 17) done0 = 1'b1;
            else k++;
        end
        idle(2);
        step(rd(13'h213), IDLE, 1'b0, 1'b1, 1'b0, 32'h1000_0013, 32'h0);
        idle(4);

        // Reset while an m1 read is in flight: that response is discarded.
        step(IDLE, rd(13'h050), 1'b0, 1'b0, 1'b1, 32'h0, 32'h5A00_0050);
        qa1.pop_back();
        qb1.pop_back();
        rst = 1'b1;
        m0_cmd_valid = 1'b1; m0_cmd_addr = 13'h060; m0_cmd_wr = 1'b0;
        m1_cmd_valid = 1'b1; m1_cmd_addr = 13'h070; m1_cmd_wr = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(rd(13'h060), rd(13'h070), 1'b0, 1'b1, 1'b0, 32'h5A00_0060, 32'h0);
        step(IDLE, rd(13'h070), 1'b0, 1'b0, 1'b1, 32'h0, 32'h5A00_0070);
        idle(8);

        chk("a_q0_left", 32'(qa0.size()), 32'd0);
        chk("a_q1_left", 32'(qa1.size()), 32'd0);
        chk("b_q0_left", 32'(qb0.size()), 32'd0);
        chk("b_q1_left", 32'(qb1.size()), 32'd0);

`ifdef DATAMEM_ARB_PERF_EN
        perf_clr = 1'b1;
        m0_cmd_valid = 1'b1;
        m1_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        m0_cmd_valid = 1'b0;
        m1_cmd_valid = 1'b0;
        chk("perf_clr_conflict", a_perf_conflict, 32'd0);
        chk("perf_clr_grant0", a_perf_grant0, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
